prime_seq_ctrl: RTL and testbench

Multi-cycle trial-division primality tester. It sequences one shared subtract/compare datapath instead of using a combinational divider array. Accepts one WIDTH-bit candidate per start/done transaction. Reports prime/composite with a single-cycle done pulse. Sits between the number-generation front end and result logging, and replaces the combinational checker on timing-critical paths.

---
 rtl/prime_seq_ctrl_if.sv | 23 ++
 rtl/prime_seq_ctrl.sv | 92 +++++++++
 tb/tb_prime_seq_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/prime_seq_ctrl_if.sv
// Handshake and result bus of the trial-division primality tester.
// The master modport drives requests; the slave modport is the tester side.
interface prime_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] number;
    logic             abort;
    logic             ready;
    logic             done;
    logic             prime;
    logic [WIDTH-1:0] result_num;

    modport master (
        output start, number, abort,
        input  ready, done, prime, result_num
    );

    modport slave (
        input  start, number, abort,
        output ready, done, prime, result_num
    );
endinterface

// File: rtl/prime_seq_ctrl.sv
// Multi-cycle trial-division primality tester built around one shared
// subtract/compare datapath: repeated subtraction stands in for a divider.
module prime_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    prime_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_DIVIDE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_r;
    logic               r_prime;
    logic [WIDTH-1:0]   r_result_num;

    logic [2*WIDTH-1:0] w_d_sq;
    logic               w_sq_gt_n;
    logic               w_r_ge_d;
    logic               w_r_zero;

    // Square is formed at double width so d=2^(WIDTH/2) cannot wrap to 0.
    assign w_d_sq    = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};
    assign w_sq_gt_n = w_d_sq > {{WIDTH{1'b0}}, r_n};
    assign w_r_ge_d  = r_r >= r_d;
    assign w_r_zero  = r_r == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_d          <= '0;
            r_r          <= '0;
            r_prime      <= 1'b0;
            r_result_num <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_n          <= bus.number;
                        r_d          <= WIDTH'(2);
                        r_result_num <= bus.number;
                        if (bus.number < WIDTH'(2)) begin
                            r_prime <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_sq_gt_n) begin
                        r_prime <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_r     <= r_n;
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    // One subtraction per clock; the leftover decides divisibility.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_r_ge_d) begin
                        r_r <= r_r - r_d;
                    end else if (w_r_zero) begin
                        r_prime <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_d     <= r_d + WIDTH'(1);
                        r_state <= S_CHECK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.prime      = r_prime;
    assign bus.result_num = r_result_num;
endmodule

// File: tb/tb_prime_seq_ctrl.sv
// Directed plus randomized checks of prime_seq_ctrl against an arithmetic
// trial-division model that predicts both the verdict and the latency.
module tb_prime_seq_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   last_prime;

    prime_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    prime_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Trial division with cycle accounting: each tested divisor costs one
    // compare, floor(n/d) subtractions and one resolving step.
    function automatic void model(input int n, output bit p, output int lat);
        lat = 1;
        p   = 1'b0;
        if (n < 2) return;
        for (int d = 2; d < 1000; d++) begin
            if (d * d > n) begin
                lat += 1;
                p = 1'b1;
                return;
            end
            lat += 2 + n / d;
            if (n % d == 0) return;
        end
    endfunction

    // Runs one candidate from accept to done; with noisy=1 start stays high
    // with random numbers during the test, which must be ignored.
    task automatic run(input int num, input bit noisy);
        bit exp_p;
        int exp_lat;
        int cyc;
        int ready_hi;
        model(num, exp_p, exp_lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.number = WIDTH'(num);
        @(posedge clk);
        #1;
        bus.start  = noisy;
        bus.number = WIDTH'($urandom);
        cyc      = 1;
        ready_hi = 0;
        while (!bus.done && cyc < 2000) begin
            if (bus.ready) ready_hi++;
            @(posedge clk);
            #1;
            if (noisy) bus.number = WIDTH'($urandom);
            cyc++;
        end
        bus.start = 1'b0;
        chk($sformatf("lat_%0d", num), cyc, exp_lat);
        chk($sformatf("prime_%0d", num), bus.prime, exp_p);
        chk($sformatf("rnum_%0d", num), bus.result_num, num);
        chk($sformatf("ready_busy_%0d", num), ready_hi + int'(bus.ready), 0);
        @(posedge clk);
        #1;
        chk($sformatf("done_once_%0d", num), bus.done, 0);
        chk($sformatf("ready_after_%0d", num), bus.ready, 1);
        last_prime = exp_p;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        last_prime = 1'b0;
        bus.start  = 1'b0;
        bus.number = '0;
        bus.abort  = 1'b0;
        rst_n      = 1'b0;
        #23;
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_prime", bus.prime, 0);
        chk("rst_rnum", bus.result_num, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Trivial, exact-latency and width-boundary candidates
        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(4, 1'b0);
        run(5, 1'b0);
        run(255, 1'b0);
        run(169, 1'b0);
        run(251, 1'b0);

        // Asynchronous reset while dividing 255
        @(negedge clk);
        bus.start  = 1'b1;
        bus.number = 8'd255;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", bus.ready, 1);
        chk("arst_done", bus.done, 0);
        chk("arst_prime", bus.prime, 0);
        chk("arst_rnum", bus.result_num, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(7, 1'b0);

        // Abort mid-test: no done, prime kept, result_num holds the accepted candidate
        begin
            int dones;
            dones = 0;
            @(negedge clk);
            bus.start  = 1'b1;
            bus.number = 8'd221;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (bus.done) dones++;
            end
            @(negedge clk);
            bus.abort = 1'b1;
            @(posedge clk);
            #1;
            bus.abort = 1'b0;
            chk("abort_ready", bus.ready, 1);
            chk("abort_prime", bus.prime, last_prime);
            chk("abort_rnum", bus.result_num, 221);
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (bus.done) dones++;
            end
            chk("abort_no_done", dones, 0);
        end

        // start held high mid-test is not queued
        run(97, 1'b1);
        run(221, 1'b1);

        for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 255)), 1'(i % 2));

        // Back-to-back sweep of every candidate
        for (int n = 0; n < 256; n++) run(n, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
